// File: rtl/indicator_writer.sv
// Binary-to-BCD indicator digit writer.
// Converts a captured binary value with shift-add-3, one bit per clock, then
// writes one digit code per clock (MSD first) with leading-zero blanking and an
// overflow marker at index 0.
module indicator_writer #(
   parameter int unsigned DIGITS     = 8,
   parameter int unsigned WIDTH      = 27,
   parameter logic [3:0]  BLANK_CODE = 4'hF,
   parameter logic [3:0]  ERR_CODE   = 4'hE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic             load_number,
   output logic             load_index,
   output logic [3:0]       number_out,
   output logic [2:0]       index_out
);

   localparam int unsigned BW = DIGITS * 4;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StConvert, StEmit, StFinish} state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [BW-1:0]    bcd_reg;
   logic [BW-1:0]    bcd_adj;
   logic [CW-1:0]    bit_cnt;
   logic [2:0]       emit_idx;
   logic             overflow;
   logic             seen_nonzero;
   logic [3:0]       cur_digit;
   logic [3:0]       code;

   // Both strobes always move together.
   assign load_index = load_number;

   // Add-3 correction of every BCD nibble ahead of the shift.
   always_comb begin
      bcd_adj = bcd_reg;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_reg[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_reg[i*4 +: 4] + 4'd3;
         end
      end
   end

   // Select the BCD digit at the current emit position.
   always_comb begin
      cur_digit = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (emit_idx == 3'(i)) begin
            cur_digit = bcd_reg[i*4 +: 4];
         end
      end
   end

   // Digit code with overflow marking and leading-zero blanking.
   always_comb begin
      if (overflow) begin
         code = (emit_idx == 3'd0) ? ERR_CODE : BLANK_CODE;
      end else if (cur_digit != 4'd0) begin
         code = cur_digit;
      end else if (!seen_nonzero && emit_idx != 3'd0) begin
         code = BLANK_CODE;
      end else begin
         code = cur_digit;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= StIdle;
         shift_reg    <= '0;
         bcd_reg      <= '0;
         bit_cnt      <= '0;
         emit_idx     <= 3'd0;
         overflow     <= 1'b0;
         seen_nonzero <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         load_number  <= 1'b0;
         number_out   <= 4'h0;
         index_out    <= 3'h0;
      end else begin
         done        <= 1'b0;
         load_number <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  shift_reg <= value;
                  bcd_reg   <= '0;
                  overflow  <= 1'b0;
                  bit_cnt   <= CW'(WIDTH);
                  busy      <= 1'b1;
                  state     <= StConvert;
               end
            end
            StConvert: begin
               {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
               // A bit leaving the top nibble means the value needs more digits.
               if (bcd_adj[BW-1]) begin
                  overflow <= 1'b1;
               end
               bit_cnt <= bit_cnt - 1'b1;
               if (bit_cnt == CW'(1)) begin
                  emit_idx     <= 3'(DIGITS - 1);
                  seen_nonzero <= 1'b0;
                  state        <= StEmit;
               end
            end
            StEmit: begin
               load_number <= 1'b1;
               number_out  <= code;
               index_out   <= emit_idx;
               if (cur_digit != 4'd0) begin
                  seen_nonzero <= 1'b1;
               end
               if (emit_idx == 3'd0) begin
                  state <= StFinish;
               end else begin
                  emit_idx <= emit_idx - 3'd1;
               end
            end
            StFinish: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_indicator_writer.sv
// Self-checking bench for indicator_writer: vector table, random values against
// a decimal reference model, and hand-written multi-cycle corner cases.
module tb_indicator_writer;

   localparam int unsigned DIGITS = 8;
   localparam int unsigned WIDTH  = 27;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] value;
   logic             busy;
   logic             done;
   logic             load_number;
   logic             load_index;
   logic [3:0]       number_out;
   logic [2:0]       index_out;

   int tests;
   int failed;

   indicator_writer #(
      .DIGITS     (DIGITS),
      .WIDTH      (WIDTH),
      .BLANK_CODE (4'hF),
      .ERR_CODE   (4'hE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .value       (value),
      .busy        (busy),
      .done        (done),
      .load_number (load_number),
      .load_index  (load_index),
      .number_out  (number_out),
      .index_out   (index_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] v;
      logic [31:0]      exp;  // nibble i = expected code at index i
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: plain decimal digits, blank above the highest nonzero digit.
   function automatic logic [31:0] model_codes(input logic [WIDTH-1:0] v);
      logic [31:0]     r;
      longint unsigned t;
      int              top;
      int              d[8];
      r   = '0;
      t   = v;
      top = 0;
      if (t >= 64'd100000000) begin
         r = 32'hFFFFFFFE;
      end else begin
         for (int i = 0; i < 8; i++) begin
            d[i] = int'(t % 10);
            t    = t / 10;
            if (d[i] != 0) top = i;
         end
         for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = (i > top) ? 4'hF : 4'(d[i]);
         end
      end
      return r;
   endfunction

   // One full conversion with timing checks; optional ignored start pulses.
   task automatic run_one(input logic [WIDTH-1:0] v, input logic [31:0] exp, input bit inject,
                          input string tag);
      int         n;
      int         first_c;
      int         done_c;
      int         dones;
      bit         li_ok;
      logic [2:0] gi[16];
      logic [3:0] gn[16];
      n = 0; first_c = -1; done_c = -1; dones = 0; li_ok = 1'b1;
      @(negedge clk);
      start = 1'b1;
      value = v;
      @(negedge clk);
      start = 1'b0;
      value = WIDTH'($urandom);
      check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (load_number) begin
            if (n < 16) begin
               gi[n] = index_out;
               gn[n] = number_out;
            end
            n++;
            if (first_c < 0) first_c = c;
         end
         if (load_index !== load_number) li_ok = 1'b0;
         if (c == 35) check({tag, " busy_last_strobe"}, 32'(busy), 32'd1);
         if (done) begin
            dones++;
            if (done_c < 0) begin
               done_c = c;
               check({tag, " busy_at_done"}, 32'(busy), 32'd0);
            end
         end
         if (inject && (c == 10 || c == 30)) begin
            start = 1'b1;
            value = WIDTH'(5);
         end else begin
            start = 1'b0;
         end
      end
      check({tag, " strobe_count"}, 32'(n), 32'd8);
      check({tag, " first_strobe_cycle"}, 32'(first_c), 32'd28);
      check({tag, " done_cycle"}, 32'(done_c), 32'd36);
      check({tag, " done_count"}, 32'(dones), 32'd1);
      check({tag, " load_index_eq"}, 32'(li_ok), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            check($sformatf("%s idx[%0d]", tag, i), 32'(gi[i]), 32'(7 - i));
            check($sformatf("%s num[%0d]", tag, i), 32'(gn[i]), 32'(exp[(7-i)*4 +: 4]));
         end
      end
   endtask

   initial begin
      int               strobes;
      int               dones;
      int               n;
      int               done_c[2];
      logic [2:0]       gi[20];
      logic [3:0]       gn[20];
      logic [WIDTH-1:0] rv;
      tests = 0; failed = 0;

      vecs[0] = '{v: 27'd1234,      exp: 32'hFFFF1234};
      vecs[1] = '{v: 27'd0,         exp: 32'hFFFFFFF0};
      vecs[2] = '{v: 27'd10203,     exp: 32'hFFF10203};
      vecs[3] = '{v: 27'd99999999,  exp: 32'h99999999};
      vecs[4] = '{v: 27'd100000000, exp: 32'hFFFFFFFE};
      vecs[5] = '{v: 27'd134217727, exp: 32'hFFFFFFFE};
      vecs[6] = '{v: 27'd10000000,  exp: 32'h10000000};
      vecs[7] = '{v: 27'd50000000,  exp: 32'h50000000};
      vecs[8] = '{v: 27'd7,         exp: 32'hFFFFFFF7};
      vecs[9] = '{v: 27'd900,       exp: 32'hFFFFF900};

      reset = 1'b1; start = 1'b0; value = '0;
      #12;
      check("reset_outputs", {21'd0, busy, done, load_number, load_index, number_out, index_out},
            32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < 10; k++) begin
         run_one(vecs[k].v, vecs[k].exp, 1'b0, $sformatf("vec%0d", k));
      end

      run_one(27'd1234, 32'hFFFF1234, 1'b1, "inject");

      for (int k = 0; k < 12; k++) begin
         case (k % 3)
            0:       rv = WIDTH'($urandom_range(0, 99999999));
            1:       rv = WIDTH'($urandom_range(0, 9999));
            default: rv = WIDTH'($urandom);
         endcase
         run_one(rv, model_codes(rv), 1'b0, $sformatf("rand%0d", k));
      end

      // Reset during emit after three strobes.
      @(negedge clk);
      start = 1'b1;
      value = 27'd12345678;
      @(negedge clk);
      start = 1'b0;
      strobes = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (load_number) strobes++;
         if (strobes == 3) break;
      end
      check("abort strobes_before_reset", 32'(strobes), 32'd3);
      reset = 1'b1;
      #1;
      check("abort async_outputs",
            {21'd0, busy, done, load_number, load_index, number_out, index_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      strobes = 0; dones = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (load_number) strobes++;
         if (done) dones++;
      end
      check("abort no_strobes", 32'(strobes), 32'd0);
      check("abort no_done", 32'(dones), 32'd0);
      run_one(27'd42, 32'hFFFFFF42, 1'b0, "after_abort");

      // Start held high: two back-to-back conversions.
      @(negedge clk);
      start = 1'b1;
      value = 27'd7;
      @(negedge clk);
      n = 0; dones = 0; done_c[0] = -1; done_c[1] = -1;
      for (int c = 1; c <= 74; c++) begin
         @(negedge clk);
         if (load_number) begin
            if (n < 20) begin
               gi[n] = index_out;
               gn[n] = number_out;
            end
            n++;
         end
         if (done) begin
            if (dones < 2) done_c[dones] = c;
            dones++;
         end
         if (c == 36) check("b2b busy_gap", 32'(busy), 32'd0);
         if (c == 37) check("b2b busy_restart", 32'(busy), 32'd1);
         if (c == 73) start = 1'b0;
      end
      check("b2b strobe_count", 32'(n), 32'd16);
      check("b2b done_count", 32'(dones), 32'd2);
      check("b2b done0_cycle", 32'(done_c[0]), 32'd36);
      check("b2b done1_cycle", 32'(done_c[1]), 32'd73);
      for (int i = 0; i < 16; i++) begin
         if (i < n) begin
            check($sformatf("b2b idx[%0d]", i), 32'(gi[i]), 32'(7 - (i % 8)));
            check($sformatf("b2b num[%0d]", i), 32'(gn[i]), (i % 8 == 7) ? 32'h7 : 32'hF);
         end
      end

      repeat (40) @(negedge clk);
      check("final idle", {30'd0, busy, load_number}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
